axi_rd_responder: RTL and testbench

- AXI4 read-channel slave (responder) for the cl_ddr0 read interface; the counterpart of the read initiator that drives AR and consumes R.
- Accepts one AR burst at a time and fetches beats from an external synchronous single-port memory (1-cycle read latency).
- Returns the beats on R with full rready backpressure, and sustains one beat per cycle when rready is held high.
- Used as the DDR/BRAM model behind design_1 and as a standalone on-chip read port.

---
 rtl/axi_rd_responder.sv | 177 +++++++++++++++++
 tb/tb_axi_rd_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_responder.sv
// AXI4 read-channel responder: one AR burst at a time, beats fetched from a 1-cycle synchronous memory.
// Latency: AR handshake at edge T -> memory read during cycle T+1 -> first R beat valid after edge T+2.
// Backpressure: 2-entry R FIFO; a read issues only while FIFO + in-flight (net of this cycle's pop) < 2.
module axi_rd_responder #(
    parameter int AXI_ADDR_WIDTH  = 42,
    parameter int AXI_ID_WIDTH    = 1,
    parameter int AXI_BURST_WIDTH = 8,
    parameter int AXI_DATA_WIDTH  = 256,
    parameter int MEM_ADDR_W      = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [AXI_ADDR_WIDTH-1:0]  s_araddr,
    input  logic [AXI_BURST_WIDTH-1:0] s_arlen,
    input  logic [2:0]                 s_arsize,
    input  logic [1:0]                 s_arburst,
    input  logic [AXI_ID_WIDTH-1:0]    s_arid,
    input  logic                       s_arvalid,
    output logic                       s_arready,
    output logic [AXI_DATA_WIDTH-1:0]  s_rdata,
    output logic [AXI_ID_WIDTH-1:0]    s_rid,
    output logic [1:0]                 s_rresp,
    output logic                       s_rlast,
    output logic                       s_rvalid,
    input  logic                       s_rready,
    output logic                       mem_rd_en,
    output logic [MEM_ADDR_W-1:0]      mem_rd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]  mem_rd_data
);

    // Byte-offset bits inside one memory word.
    localparam int OFF = $clog2(AXI_DATA_WIDTH / 8);
    // Beat counter needs one extra bit so it can run past arlen (= "all issued").
    localparam int CW  = AXI_BURST_WIDTH + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0] dat;
        logic                      err;
        logic                      last;
    } beat_t;

    // Burst context and sequencing state
    logic [0:0]                 state_q, state_d;
    logic                       arready_q;
    logic [AXI_ADDR_WIDTH-1:0]  addr_q;      // byte address of the next beat to issue
    logic [AXI_ADDR_WIDTH-1:0]  base_q;      // original araddr, reused by FIXED bursts
    logic [AXI_BURST_WIDTH-1:0] len_q;
    logic [2:0]                 size_q;
    logic                       fixed_q;
    logic                       oversize_q;
    logic [AXI_ID_WIDTH-1:0]    id_q;
    logic [CW-1:0]              issue_cnt_q;

    // One read in flight between issue and FIFO write
    logic                       inf_vld_q;
    logic                       inf_err_q;
    logic                       inf_last_q;

    // Output FIFO
    beat_t                      fifo_q [2];
    logic                       wr_ptr_q;
    logic                       rd_ptr_q;
    logic [1:0]                 cnt_q, cnt_d;

    // Combinational helpers
    logic                       ar_hs;
    logic                       r_vld;
    logic                       r_pop;
    beat_t                      head;
    logic                       issue_pend;
    logic [2:0]                 occ_eff;
    logic                       issue;
    logic                       beat_err;
    logic                       beat_last;
    logic [AXI_ADDR_WIDTH-1:0]  step;
    logic [AXI_ADDR_WIDTH-1:0]  addr_nxt;

    // Issue decision, next-beat address and FSM next state
    always_comb begin
        ar_hs      = s_arvalid && arready_q;
        head       = fifo_q[rd_ptr_q];
        r_vld      = (cnt_q != 2'd0);
        r_pop      = r_vld && s_rready;

        issue_pend = (state_q == BURST) && (issue_cnt_q <= {1'b0, len_q});
        // A slot freed by this cycle's pop can be reused immediately, which is
        // what lets the pipeline sustain one beat per cycle.
        occ_eff    = {1'b0, cnt_q} + {2'b0, inf_vld_q} - {2'b0, r_pop};
        issue      = issue_pend && (occ_eff < 3'd2);

        beat_err   = oversize_q || (addr_q[AXI_ADDR_WIDTH-1:MEM_ADDR_W+OFF] != '0);
        beat_last  = (issue_cnt_q == {1'b0, len_q});

        // INCR (and WRAP/reserved, treated the same): align down, then step by 2^size.
        step       = {{(AXI_ADDR_WIDTH-1){1'b0}}, 1'b1} << size_q;
        addr_nxt   = fixed_q ? base_q
                             : ((addr_q & ({AXI_ADDR_WIDTH{1'b1}} << size_q)) + step);

        state_d = state_q;
        case (state_q)
            IDLE:    if (ar_hs) state_d = BURST;
            BURST:   if (r_pop && head.last) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        cnt_d = cnt_q + {1'b0, inf_vld_q} - {1'b0, r_pop};
    end

    // Burst capture, beat issue and in-flight tracking
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            arready_q   <= 1'b0;
            addr_q      <= '0;
            base_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            fixed_q     <= 1'b0;
            oversize_q  <= 1'b0;
            id_q        <= '0;
            issue_cnt_q <= '0;
            inf_vld_q   <= 1'b0;
            inf_err_q   <= 1'b0;
            inf_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            arready_q  <= (state_d == IDLE);
            inf_vld_q  <= issue;
            inf_err_q  <= beat_err;
            inf_last_q <= beat_last;
            if (ar_hs) begin
                addr_q      <= s_araddr;
                base_q      <= s_araddr;
                len_q       <= s_arlen;
                size_q      <= s_arsize;
                fixed_q     <= (s_arburst == 2'b00);
                oversize_q  <= (int'(s_arsize) > OFF);
                id_q        <= s_arid;
                issue_cnt_q <= '0;
            end else if (issue) begin
                addr_q      <= addr_nxt;
                issue_cnt_q <= issue_cnt_q + CW'(1);
            end
        end
    end

    // Output FIFO: written the cycle after issue, popped on the R handshake
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (inf_vld_q) begin
                fifo_q[wr_ptr_q] <= '{dat:  (inf_err_q ? '0 : mem_rd_data),
                                       err:  inf_err_q,
                                       last: inf_last_q};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (r_pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_d;
        end
    end

    assign s_arready   = arready_q;
    assign s_rvalid    = r_vld;
    assign s_rdata     = r_vld ? head.dat : '0;
    assign s_rresp     = {r_vld && head.err, 1'b0};
    assign s_rlast     = r_vld && head.last;
    assign s_rid       = id_q;
    assign mem_rd_en   = issue && !beat_err;
    assign mem_rd_addr = addr_q[OFF +: MEM_ADDR_W];

endmodule

// File: tb/tb_axi_rd_responder.sv
`timescale 1ns/1ps
module tb_axi_rd_responder;
    localparam int AW  = 42;
    localparam int IW  = 1;
    localparam int BW  = 8;
    localparam int DW  = 256;
    localparam int MW  = 10;
    localparam int OFF = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic [AW-1:0]  s_araddr;
    logic [BW-1:0]  s_arlen;
    logic [2:0]     s_arsize;
    logic [1:0]     s_arburst;
    logic [IW-1:0]  s_arid;
    logic           s_arvalid;
    logic           s_arready;
    logic [DW-1:0]  s_rdata;
    logic [IW-1:0]  s_rid;
    logic [1:0]     s_rresp;
    logic           s_rlast;
    logic           s_rvalid;
    logic           s_rready;
    logic           mem_rd_en;
    logic [MW-1:0]  mem_rd_addr;
    logic [DW-1:0]  mem_rd_data = '0;

    axi_rd_responder #(
        .AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW), .AXI_BURST_WIDTH(BW),
        .AXI_DATA_WIDTH(DW), .MEM_ADDR_W(MW)
    ) dut (
        .clk(clk), .reset(reset),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arid(s_arid), .s_arvalid(s_arvalid),
        .s_arready(s_arready), .s_rdata(s_rdata), .s_rid(s_rid),
        .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
        .s_rready(s_rready), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_cnt = 0;

    // Backing memory: word w holds w in every 32-bit lane, 1-cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en) begin
            rd_cnt      <= rd_cnt + 1;
            mem_rd_data <= {8{32'(mem_rd_addr)}};
        end
    end

    typedef struct {
        logic [DW-1:0] dat;
        logic [1:0]    resp;
        logic          last;
        logic          chk_dat;
    } exp_t;

    exp_t exp_q[$];
    int   hs_edge;
    int   cur_len;
    logic cur_id;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    // Reference: list of expected beats computed from the address rules.
    task automatic build_exp(input longint a, input int len, input int size, input int burst);
        longint amask = (longint'(1) << AW) - 1;
        longint st    = longint'(1) << size;
        exp_q.delete();
        for (int k = 0; k <= len; k++) begin
            longint ba;
            exp_t   e;
            if (burst == 0 || k == 0) ba = a;
            else ba = ((a & ~(st - 1)) + k * st) & amask;
            e.last = (k == len);
            if (size > OFF) begin
                e.resp = 2'b10; e.dat = '0; e.chk_dat = 1'b0;
            end else if ((ba >> (MW + OFF)) != 0) begin
                e.resp = 2'b10; e.dat = '0; e.chk_dat = 1'b1;
            end else begin
                e.resp = 2'b00; e.dat = {8{32'((ba >> OFF) & 1023)}}; e.chk_dat = 1'b1;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic do_ar(input longint a, input int len, input int size, input int burst, input logic id);
        int budget = 0;
        build_exp(a, len, size, burst);
        cur_len = len;
        cur_id  = id;
        @(negedge clk);
        s_araddr  = a[AW-1:0];
        s_arlen   = 8'(len);
        s_arsize  = 3'(size);
        s_arburst = 2'(burst);
        s_arid    = id;
        s_arvalid = 1'b1;
        while (!s_arready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("ar_accept", s_arready, 1);
        hs_edge = cyc + 1;
        @(negedge clk);
        s_arvalid = 1'b0;
    endtask

    // mode 0: rready always 1; mode 1: rready 0 for 7 cycles after AR; mode 2: random.
    task automatic do_r(input int mode, output int nreads);
        int   rel;
        int   first = -1;
        int   lastrel = -1;
        int   rd0 = rd_cnt;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [DW-1:0] pd = '0;
        logic [2:0]    pctl = '0;
        for (int t = 0; t < 3000 && exp_q.size() > 0; t++) begin
            rel = cyc - hs_edge;
            case (mode)
                0:       s_rready = 1'b1;
                1:       s_rready = (rel >= 7);
                default: s_rready = 1'($urandom_range(0, 1));
            endcase
            if (mode == 1 && rel == 7) chk("stall_reads", rd_cnt - rd0, 2);
            chk("arready_busy", s_arready, 0);
            if (s_rvalid) begin
                if (first < 0) begin
                    first = rel;
                    chk("first_latency", rel, 2);
                end
                if (pv && !pr) begin
                    chk("stable_dat", s_rdata, pd);
                    chk("stable_ctl", {s_rresp, s_rlast}, pctl);
                end
                if (s_rready) begin
                    exp_t e = exp_q.pop_front();
                    if (e.chk_dat) chk("rdata", s_rdata, e.dat);
                    chk("rresp", s_rresp, e.resp);
                    chk("rlast", s_rlast, e.last);
                    chk("rid", s_rid, cur_id);
                    lastrel = rel;
                end
            end
            pv = s_rvalid; pr = s_rready; pd = s_rdata; pctl = {s_rresp, s_rlast};
            @(negedge clk);
        end
        chk("beats_left", exp_q.size(), 0);
        if (mode == 0) chk("back_to_back", lastrel, 2 + cur_len);
        chk("arready_after", s_arready, 1);
        chk("rvalid_after", s_rvalid, 0);
        nreads = rd_cnt - rd0;
    endtask

    initial begin
        int   nr;
        exp_t e;
        reset = 1'b0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
        s_arid = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_arready", s_arready, 0);
        chk("rst_rvalid", s_rvalid, 0);
        chk("rst_rdata", s_rdata, 0);
        chk("rst_rresp_rlast", {s_rresp, s_rlast}, 0);
        chk("rst_rid", s_rid, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("arready_post_rst", s_arready, 1);

        // INCR, no backpressure
        do_ar(64'h1000, 4, 5, 1, 1'b1);
        do_r(0, nr);
        chk("incr_reads", nr, 5);

        // Late rready
        do_ar(64'h1000, 4, 5, 1, 1'b0);
        do_r(1, nr);
        chk("late_reads", nr, 5);

        // 256-beat burst with random backpressure
        do_ar(64'h0, 255, 5, 1, 1'b1);
        do_r(2, nr);
        chk("long_reads", nr, 256);

        // FIXED
        do_ar(64'h40, 3, 5, 0, 1'b0);
        do_r(0, nr);
        chk("fixed_reads", nr, 4);

        // Out of range: no memory reads at all
        do_ar(64'h8000, 3, 5, 1, 1'b1);
        do_r(0, nr);
        chk("oor_reads", nr, 0);

        // Oversize beat
        do_ar(64'h1000, 2, 6, 1, 1'b0);
        do_r(0, nr);

        // Random bursts
        for (int i = 0; i < 8; i++) begin
            do_ar(longint'($urandom_range(0, 32'h9000)), int'($urandom_range(0, 20)),
                  int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            do_r(2, nr);
        end

        // Reset during beat 2 of 5
        do_ar(64'h1000, 4, 5, 1, 1'b1);
        for (int t = 0; t < 40 && !(s_rvalid && exp_q.size() == 3); t++) begin
            s_rready = 1'b1;
            if (s_rvalid) begin
                e = exp_q.pop_front();
                chk("pre_rst_rdata", s_rdata, e.dat);
            end
            @(negedge clk);
        end
        chk("rst_at_beat2", exp_q.size(), 3);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_rvalid", s_rvalid, 0);
        chk("midrst_arready", s_arready, 0);
        chk("midrst_mem_rd_en", mem_rd_en, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_arready_rel", s_arready, 1);
        for (int t = 0; t < 3; t++) begin
            chk("midrst_no_beats", s_rvalid, 0);
            @(negedge clk);
        end
        do_ar(64'h3000, 2, 5, 1, 1'b0);
        do_r(0, nr);
        chk("post_rst_reads", nr, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
